river_crossing: RTL and testbench
=================================

Name: river_crossing

Overview:
- Parametrised successor of the 3-item farmer puzzle core: N items, boat capacity, configurable predator/prey matrix.
- Accepts move requests over a valid/ready handshake, validates each move, and applies legal moves to a registered bank-state vector.
- Detects loss (unattended conflict) and win (everything on far bank); counts moves.
- Driven by a bench-side controller or a solver block.

Parameters:
- N_ITEMS, 3, number of passengers excluding farmer.
- BOAT_CAP, 1, max items carried per crossing (0 items = farmer crosses alone).
- EAT_MASK, 9'h088, N_ITEMS*N_ITEMS bits; bit [i*N_ITEMS+j]=1 means item i eats item j when the farmer is absent.
- CNT_W, 8, move counter width.
- UNDO_DEPTH, 4, history entries (used only with RC_UNDO_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- move_valid  in  1  move request present.
- move_mask  in  N_ITEMS  items to carry this crossing.
- move_ready  out  1  move can be accepted this cycle.
- undo  in  1  revert last move (ignored without RC_UNDO_EN).
- state  out  N_ITEMS+1  bank per item; bit N_ITEMS = farmer; 0 = start bank, 1 = far bank.
- reject  out  1  one-cycle pulse: request refused.
- error  out  1  conflict present in state.
- done  out  1  win reached.
- move_count  out  CNT_W  accepted moves, saturating.

Behaviour:
- Reset (rst=0, async): state=0, move_count=0, reject=0, FSM=PLAY, history empty. Reset mid-game discards all progress immediately.
- FSM states:
  - PLAY -> FAIL when the applied move produces a conflict.
  - PLAY -> DONE when state is all ones with no conflict.
  - FAIL and DONE are sticky until reset (see undo exception below).
- move_ready = (FSM==PLAY) & !undo.
- Acceptance: move_valid & move_ready, sampled on the clk edge.
- Legal move: popcount(move_mask) <= BOAT_CAP, and every selected item is on the farmer's bank.
- Legal move effect, next edge:
  - Farmer bit toggles.
  - Selected item bits toggle.
  - move_count increments, saturating at 2^CNT_W-1.
  - Latency 1 cycle.
- Illegal move: state and count unchanged; reject=1 for exactly the next cycle; FSM stays in PLAY.
- error is combinational from registered state: any i!=j with EAT_MASK[i*N+j]=1, state[i]==state[j], state[i]!=state[N].
- done = (state all ones) & !error.
- Requests in FAIL/DONE are not accepted and produce no reject.
- Back-to-back legal moves are accepted every cycle.

Optional Feature:
- Macro: RC_UNDO_EN.
- With RC_UNDO_EN, a circular history holds the last UNDO_DEPTH accepted masks.
  - On undo=1 in PLAY or FAIL: pop the last mask, re-toggle those items and the farmer, decrement move_count (floored at 0), and go to PLAY. Takes 1 cycle.
  - Undo with an empty history: reject pulse, nothing else.
  - Undo has priority over a simultaneous move_valid (move_ready=0 that cycle).
  - History full on a new move: the oldest entry is overwritten.
  - Undo is ignored in DONE.
- Without RC_UNDO_EN: undo is ignored, no history storage, FAIL is strictly sticky.

Decomposition:
- Package rc_pkg contains:
  - rc_fsm_e {PLAY, DONE, FAIL}.
  - Function popcount.
  - Default 3-item EAT_MASK constant RC_WSC_EAT = 9'h088 (wolf=2 eats sheep=1, sheep=1 eats cab=0).
- One sub-module, rc_conflict_check: combinational; inputs state and EAT_MASK; output error.

Test Plan:
- Defaults, mask sequence 010,000,100,010,001,000,010 on consecutive cycles -> state 4'hF, done=1, error=0, move_count=7, move_ready=0.
- From reset, mask 100 -> state 4'b1100, error=1, FSM FAIL; further valid moves give no state change and no reject.
- From reset, mask 011 (exceeds BOAT_CAP=1) -> reject pulse 1 cycle, state 0, move_count 0.
- After mask 010 (state 4'b1010), request 001 (cab not on farmer bank) -> reject; state stays 4'b1010.
- Assert rst=0 asynchronously mid-sequence after 3 moves -> state=0, move_count=0, reject=0 before the next edge.
- RC_UNDO_EN: mask 100 (FAIL), then undo -> state 0, move_count 0, FSM PLAY. Second undo -> reject. Undo together with move_valid -> the move is not accepted.

Source files
------------

// File: rtl/rc_pkg.sv
// Shared types and helpers for the river-crossing puzzle core.
package rc_pkg;

  typedef enum logic [1:0] {PLAY, DONE, FAIL} rc_fsm_e;

  localparam int RC_MAX_ITEMS = 32;

  // Wolf (2) eats sheep (1), sheep (1) eats cabbage (0).
  localparam logic [8:0] RC_WSC_EAT = 9'h088;

  function automatic int popcount(input logic [RC_MAX_ITEMS-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < RC_MAX_ITEMS; i++) c = c + int'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/rc_conflict_check.sv
// Combinational predator/prey check: flags any eater left alone with its prey
// on the bank opposite the farmer.
module rc_conflict_check #(
  parameter int N_ITEMS = 3
) (
  input  logic [N_ITEMS:0]           state,
  input  logic [N_ITEMS*N_ITEMS-1:0] eat_mask,
  output logic                       error
);

  always_comb begin
    error = 1'b0;
    for (int i = 0; i < N_ITEMS; i++) begin
      for (int j = 0; j < N_ITEMS; j++) begin
        if (i != j && eat_mask[i*N_ITEMS+j] &&
            state[i] == state[j] && state[i] != state[N_ITEMS])
          error = 1'b1;
      end
    end
  end

endmodule

// File: rtl/river_crossing.sv
// River-crossing puzzle core: validates and applies crossings, tracks win/loss.
// Define RC_UNDO_EN to add a circular move history with single-step undo.
module river_crossing
  import rc_pkg::*;
#(
  parameter int                           N_ITEMS    = 3,
  parameter int                           BOAT_CAP   = 1,
  parameter logic [N_ITEMS*N_ITEMS-1:0]   EAT_MASK   = RC_WSC_EAT,
  parameter int                           CNT_W      = 8,
  parameter int                           UNDO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               move_valid,
  input  logic [N_ITEMS-1:0] move_mask,
  output logic               move_ready,
  input  logic               undo,
  output logic [N_ITEMS:0]   state,
  output logic               reject,
  output logic               error,
  output logic               done,
  output logic [CNT_W-1:0]   move_count
);

  localparam int N = N_ITEMS;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] floor_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - CNT_W'(1);
  endfunction

  logic [N:0]       state_q, state_d;
  rc_fsm_e          fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reject_q, reject_d;

  logic [N:0]       moved_state;
  logic             err_cur, err_nxt;
  logic             move_legal, accept;

  // One checker watches the registered state, the other the candidate move.
  rc_conflict_check #(.N_ITEMS(N)) u_check_cur (
    .state    (state_q),
    .eat_mask (EAT_MASK),
    .error    (err_cur)
  );

  rc_conflict_check #(.N_ITEMS(N)) u_check_nxt (
    .state    (moved_state),
    .eat_mask (EAT_MASK),
    .error    (err_nxt)
  );

  assign moved_state = state_q ^ {1'b1, move_mask};
  // Items must share the farmer's bank: bank bit XOR farmer bit must be 0.
  assign move_legal  = (popcount(RC_MAX_ITEMS'(move_mask)) <= BOAT_CAP) &&
                       ((move_mask & (state_q[N-1:0] ^ {N{state_q[N]}})) == '0);

`ifdef RC_UNDO_EN
  localparam int PTR_W  = (UNDO_DEPTH > 1) ? $clog2(UNDO_DEPTH) : 1;
  localparam int HCNT_W = $clog2(UNDO_DEPTH + 1);

  logic [N-1:0]      hist_q [UNDO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d, top_idx, wptr_inc;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              hist_we;
  logic              undo_act;

  assign undo_act   = undo && (fsm_q != DONE);
  assign move_ready = (fsm_q == PLAY) && !undo;
  assign top_idx    = (wptr_q == '0) ? PTR_W'(UNDO_DEPTH - 1) : wptr_q - PTR_W'(1);
  assign wptr_inc   = (wptr_q == PTR_W'(UNDO_DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
`else
  logic unused_undo;
  assign unused_undo = undo ^ UNDO_DEPTH[0];
  assign move_ready  = (fsm_q == PLAY);
`endif

  assign accept = move_valid && move_ready;

  always_comb begin
    state_d  = state_q;
    fsm_d    = fsm_q;
    cnt_d    = cnt_q;
    reject_d = 1'b0;
`ifdef RC_UNDO_EN
    wptr_d   = wptr_q;
    hcnt_d   = hcnt_q;
    hist_we  = 1'b0;
    if (undo_act) begin
      if (hcnt_q == '0) begin
        reject_d = 1'b1;
      end else begin
        state_d = state_q ^ {1'b1, hist_q[top_idx]};
        cnt_d   = floor_dec(cnt_q);
        wptr_d  = top_idx;
        hcnt_d  = hcnt_q - HCNT_W'(1);
        fsm_d   = PLAY;
      end
    end else
`endif
    if (accept) begin
      if (move_legal) begin
        state_d = moved_state;
        cnt_d   = sat_inc(cnt_q);
        if (err_nxt)          fsm_d = FAIL;
        else if (&moved_state) fsm_d = DONE;
        else                  fsm_d = PLAY;
`ifdef RC_UNDO_EN
        hist_we = 1'b1;
        wptr_d  = wptr_inc;
        if (hcnt_q != HCNT_W'(UNDO_DEPTH)) hcnt_d = hcnt_q + HCNT_W'(1);
`endif
      end else begin
        reject_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= '0;
      fsm_q    <= PLAY;
      cnt_q    <= '0;
      reject_q <= 1'b0;
`ifdef RC_UNDO_EN
      wptr_q   <= '0;
      hcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      fsm_q    <= fsm_d;
      cnt_q    <= cnt_d;
      reject_q <= reject_d;
`ifdef RC_UNDO_EN
      wptr_q   <= wptr_d;
      hcnt_q   <= hcnt_d;
`endif
    end
  end

`ifdef RC_UNDO_EN
  // History payload needs no reset; hcnt_q alone marks which entries are live.
  always_ff @(posedge clk) begin
    if (hist_we) hist_q[wptr_q] <= move_mask;
  end
`endif

  assign state      = state_q;
  assign reject     = reject_q;
  assign error      = err_cur;
  assign done       = (&state_q) && !err_cur;
  assign move_count = cnt_q;

endmodule

// File: tb/tb_river_crossing.sv
// Directed bench for river_crossing with the default wolf/sheep/cabbage setup.
// Undo scenarios are exercised when RC_UNDO_EN is defined.
module tb_river_crossing;

  logic       clk;
  logic       rst;
  logic       move_valid;
  logic [2:0] move_mask;
  logic       move_ready;
  logic       undo;
  logic [3:0] state;
  logic       reject;
  logic       error;
  logic       done;
  logic [7:0] move_count;

  int n_checks;
  int n_errors;

  river_crossing dut (
    .clk        (clk),
    .rst        (rst),
    .move_valid (move_valid),
    .move_mask  (move_mask),
    .move_ready (move_ready),
    .undo       (undo),
    .state      (state),
    .reject     (reject),
    .error      (error),
    .done       (done),
    .move_count (move_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a request at the falling edge; returns one falling edge later.
  task automatic do_move(input logic [2:0] m);
    move_valid = 1'b1;
    move_mask  = m;
    @(negedge clk);
  endtask

  task automatic idle();
    move_valid = 1'b0;
    move_mask  = 3'b000;
    undo       = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    move_valid = 1'b0;
    undo       = 1'b0;
    rst        = 1'b0;
    @(negedge clk);
    rst        = 1'b1;
  endtask

  logic [2:0] win_masks [7];
  logic [3:0] win_states [7];

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b0;
    move_valid = 1'b0;
    move_mask  = 3'b000;
    undo       = 1'b0;
    win_masks  = '{3'b010, 3'b000, 3'b100, 3'b010, 3'b001, 3'b000, 3'b010};
    win_states = '{4'b1010, 4'b0010, 4'b1110, 4'b0100, 4'b1101, 4'b0101, 4'b1111};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_state", state, 4'h0);
    chk("rst_count", move_count, 8'd0);
    chk("rst_reject", reject, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", move_ready, 1'b1);
    rst = 1'b1;

    // Winning sequence on consecutive cycles
    for (int k = 0; k < 7; k++) begin
      do_move(win_masks[k]);
      chk($sformatf("win_state%0d", k), state, win_states[k]);
      chk($sformatf("win_rej%0d", k), reject, 1'b0);
    end
    chk("win_done", done, 1'b1);
    chk("win_error", error, 1'b0);
    chk("win_count", move_count, 8'd7);
    chk("win_ready", move_ready, 1'b0);
    do_move(3'b000);
    chk("done_sticky_state", state, 4'hF);
    chk("done_no_reject", reject, 1'b0);
    chk("done_count", move_count, 8'd7);
    idle();

    // Losing move: wolf crosses, sheep left with cabbage
    apply_reset();
    do_move(3'b100);
    chk("lose_state", state, 4'b1100);
    chk("lose_error", error, 1'b1);
    chk("lose_done", done, 1'b0);
    chk("lose_ready", move_ready, 1'b0);
    chk("lose_count", move_count, 8'd1);
    do_move(3'b010);
    chk("fail_sticky_state", state, 4'b1100);
    chk("fail_no_reject", reject, 1'b0);
    chk("fail_count", move_count, 8'd1);
    idle();

    // Overloaded boat
    apply_reset();
    do_move(3'b011);
    chk("cap_reject", reject, 1'b1);
    chk("cap_state", state, 4'h0);
    chk("cap_count", move_count, 8'd0);
    chk("cap_ready", move_ready, 1'b1);
    idle();
    chk("cap_reject_clear", reject, 1'b0);

    // Item not on farmer's bank
    do_move(3'b010);
    chk("bank_pre_state", state, 4'b1010);
    do_move(3'b001);
    chk("bank_reject", reject, 1'b1);
    chk("bank_state", state, 4'b1010);
    chk("bank_count", move_count, 8'd1);
    idle();

    // Asynchronous reset mid-game, landing between clock edges
    apply_reset();
    do_move(3'b010);
    do_move(3'b000);
    do_move(3'b100);
    do_move(3'b011);
    chk("ar_pre_state", state, 4'b1110);
    chk("ar_pre_reject", reject, 1'b1);
    chk("ar_pre_count", move_count, 8'd3);
    move_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("ar_state", state, 4'h0);
    chk("ar_count", move_count, 8'd0);
    chk("ar_reject", reject, 1'b0);
    @(negedge clk);
    rst = 1'b1;

`ifdef RC_UNDO_EN
    // Undo out of FAIL
    apply_reset();
    do_move(3'b100);
    chk("undo_pre_err", error, 1'b1);
    move_valid = 1'b0;
    undo = 1'b1;
    @(negedge clk);
    chk("undo_state", state, 4'h0);
    chk("undo_count", move_count, 8'd0);
    chk("undo_reject", reject, 1'b0);
    chk("undo_ready_held", move_ready, 1'b0);
    undo = 1'b0;
    #1;
    chk("undo_play", move_ready, 1'b1);
    @(negedge clk);
    undo = 1'b1;
    @(negedge clk);
    chk("undo_empty_reject", reject, 1'b1);
    chk("undo_empty_state", state, 4'h0);
    idle();
    // Undo beats a simultaneous move
    do_move(3'b010);
    chk("undo_mv_pre", state, 4'b1010);
    move_valid = 1'b1;
    move_mask  = 3'b000;
    undo       = 1'b1;
    #1;
    chk("undo_mv_ready", move_ready, 1'b0);
    @(negedge clk);
    chk("undo_mv_state", state, 4'h0);
    chk("undo_mv_count", move_count, 8'd0);
    idle();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
